// File: rtl/ld_use_stall_pkg.sv
// Shared ID-stage hazard definitions: register file geometry, load tracking limits
// and forwarding-select codes used by the neighbouring forwarding selector.
package ld_use_stall_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned MAX_LD   = 2;
    localparam int unsigned CNT_W    = 16;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // r0 is hard-wired zero and never carries a hazard
    function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
        return r == REG_ZERO;
    endfunction

endpackage

// File: rtl/ld_scoreboard.sv
// Per-register pending-load bit array: clear on writeback, set on load issue,
// with a small set of combinational index lookups.
module ld_scoreboard
    import ld_use_stall_pkg::*;
#(
    parameter int unsigned SB_REGS  = NUM_REGS,
    parameter int unsigned SB_IDX_W = REG_W,
    parameter int unsigned NUM_LK   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr_en_i,
    input  logic [SB_IDX_W-1:0]                clr_idx_i,
    input  logic                               set_en_i,
    input  logic [SB_IDX_W-1:0]                set_idx_i,
    input  logic [NUM_LK-1:0][SB_IDX_W-1:0]    lk_idx_i,
    output logic [NUM_LK-1:0]                  lk_hit_o,
    output logic [SB_REGS-1:0]                 pending_o
);

    logic [SB_REGS-1:0] pend_q;
    logic [SB_REGS-1:0] pend_d;

    // Clear first so a same-register release and re-issue leaves the bit set
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            pend_d[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        lk_hit_o = '0;
        for (int k = 0; k < int'(NUM_LK); k++) begin
            lk_hit_o[k] = pend_q[lk_idx_i[k]];
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/ld_use_stall.sv
// Load-use hazard unit: tracks in-flight loads and stalls ID on RAW/WAW against
// them or when the load queue is full; keeps an error flag and stall counter.
module ld_use_stall
    import ld_use_stall_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_ID,
    input  logic                      flush_ID,
    input  logic [REG_W-1:0]          rdReg1_ID,
    input  logic [REG_W-1:0]          rdReg2_ID,
    input  logic                      rdEn1_ID,
    input  logic                      rdEn2_ID,
    input  logic [REG_W-1:0]          wrReg_ID,
    input  logic                      wrEn_ID,
    input  logic                      isLoad_ID,
    input  logic                      memStall,
    input  logic                      ldDone_WB,
    input  logic [REG_W-1:0]          ldReg_WB,
    output logic                      stall_ID,
    output logic                      bubble_EX,
    output logic [NUM_REGS-1:0]       ldPending,
    output logic [$clog2(MAX_LD):0]   ldCount,
    output logic                      sbErr,
    output logic [CNT_W-1:0]          stallCnt
);

    localparam int unsigned LDCNT_W = $clog2(MAX_LD) + 1;
    localparam int unsigned NUM_LK  = 4;
    localparam logic [LDCNT_W-1:0] LD_FULL = LDCNT_W'(MAX_LD);

    logic [NUM_LK-1:0][REG_W-1:0] lk_idx;
    logic [NUM_LK-1:0]            lk_hit;
    logic [NUM_REGS-1:0]          pending;

    logic [LDCNT_W-1:0] ld_count_q, ld_count_d;
    logic               sb_err_q, sb_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic rel1, rel2, relw;
    logic raw1, raw2, waw, structural;
    logic stall, advance, issue, done_hit;

    assign lk_idx = {ldReg_WB, wrReg_ID, rdReg2_ID, rdReg1_ID};

    ld_scoreboard #(
        .SB_REGS  (NUM_REGS),
        .SB_IDX_W (REG_W),
        .NUM_LK   (NUM_LK)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_en_i  (ldDone_WB),
        .clr_idx_i (ldReg_WB),
        .set_en_i  (issue),
        .set_idx_i (wrReg_ID),
        .lk_idx_i  (lk_idx),
        .lk_hit_o  (lk_hit),
        .pending_o (pending)
    );

    // A register released at WB this cycle is forwarded, so it is not a hazard
    always_comb begin
        rel1 = ldDone_WB & (ldReg_WB == rdReg1_ID);
        rel2 = ldDone_WB & (ldReg_WB == rdReg2_ID);
        relw = ldDone_WB & (ldReg_WB == wrReg_ID);

        raw1 = rdEn1_ID & ~is_zero_reg(rdReg1_ID) & lk_hit[0] & ~rel1;
        raw2 = rdEn2_ID & ~is_zero_reg(rdReg2_ID) & lk_hit[1] & ~rel2;
        waw  = wrEn_ID  & ~is_zero_reg(wrReg_ID)  & lk_hit[2] & ~relw;
        structural = isLoad_ID & wrEn_ID & (ld_count_q == LD_FULL) & ~ldDone_WB;

        stall    = valid_ID & ~flush_ID & (raw1 | raw2 | waw | structural);
        advance  = valid_ID & ~flush_ID & ~stall & ~memStall;
        issue    = advance & isLoad_ID & wrEn_ID & ~is_zero_reg(wrReg_ID);
        done_hit = ldDone_WB & lk_hit[3];
    end

    always_comb begin
        ld_count_d  = ld_count_q;
        sb_err_d    = sb_err_q;
        stall_cnt_d = stall_cnt_q;

        if (issue && !done_hit && ld_count_q != LD_FULL) begin
            ld_count_d = ld_count_q + LDCNT_W'(1);
        end else if (!issue && done_hit && ld_count_q != '0) begin
            ld_count_d = ld_count_q - LDCNT_W'(1);
        end

        if (ldDone_WB && !lk_hit[3]) begin
            sb_err_d = 1'b1;
        end

        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_count_q  <= '0;
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ld_count_q  <= ld_count_d;
            sb_err_q    <= sb_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_ID  = stall;
    assign bubble_EX = stall & ~memStall;
    assign ldPending = pending;
    assign ldCount   = ld_count_q;
    assign sbErr     = sb_err_q;
    assign stallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_ld_use_stall.sv
// Bench for ld_use_stall: directed vector table, hand-written corner sequences,
// then random traffic against a register-set reference model.
module tb_ld_use_stall;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_ID, flush_ID, rdEn1_ID, rdEn2_ID, wrEn_ID, isLoad_ID;
    logic        memStall, ldDone_WB;
    logic [3:0]  rdReg1_ID, rdReg2_ID, wrReg_ID, ldReg_WB;
    logic        stall_ID, bubble_EX, sbErr;
    logic [15:0] ldPending;
    logic [1:0]  ldCount;
    logic [15:0] stallCnt;

    int vectors = 0;
    int miscompares = 0;

    ld_use_stall dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_ID  (valid_ID),
        .flush_ID  (flush_ID),
        .rdReg1_ID (rdReg1_ID),
        .rdReg2_ID (rdReg2_ID),
        .rdEn1_ID  (rdEn1_ID),
        .rdEn2_ID  (rdEn2_ID),
        .wrReg_ID  (wrReg_ID),
        .wrEn_ID   (wrEn_ID),
        .isLoad_ID (isLoad_ID),
        .memStall  (memStall),
        .ldDone_WB (ldDone_WB),
        .ldReg_WB  (ldReg_WB),
        .stall_ID  (stall_ID),
        .bubble_EX (bubble_EX),
        .ldPending (ldPending),
        .ldCount   (ldCount),
        .sbErr     (sbErr),
        .stallCnt  (stallCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, fl;
        logic [3:0] r1;
        logic       e1;
        logic [3:0] r2;
        logic       e2;
        logic [3:0] wr;
        logic       we, ld, ms, dn;
        logic [3:0] dr;
        logic       st, bu;
        logic [15:0] pend;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        valid_ID = t.v;  flush_ID = t.fl;
        rdReg1_ID = t.r1; rdEn1_ID = t.e1;
        rdReg2_ID = t.r2; rdEn2_ID = t.e2;
        wrReg_ID = t.wr; wrEn_ID = t.we; isLoad_ID = t.ld;
        memStall = t.ms; ldDone_WB = t.dn; ldReg_WB = t.dr;
    endtask

    task automatic idle();
        vec_t t;
        t = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,0,16'h0,0};
        drive(t);
    endtask

    // Reference model state: the set of registers with a load in flight
    logic [15:0] m_pend;
    logic        m_err;
    int          m_stall_cnt;

    function automatic logic busy(input logic [3:0] r);
        return (r != 0) && m_pend[r] && !(ldDone_WB && ldReg_WB == r);
    endfunction

    function automatic logic model_stall();
        logic h;
        h = (rdEn1_ID && busy(rdReg1_ID)) || (rdEn2_ID && busy(rdReg2_ID))
            || (wrEn_ID && busy(wrReg_ID))
            || (isLoad_ID && wrEn_ID && $countones(m_pend) == 2 && !ldDone_WB);
        return valid_ID && !flush_ID && h;
    endfunction

    initial begin
        vec_t t;
        logic exp_st;
        logic [3:0] pick;

        tbl[0]  = '{1,0,0,0,0,0,3,1,1,0,0,0, 0,0,16'h0008,1};
        tbl[1]  = '{1,0,3,1,0,0,6,1,0,0,0,0, 1,1,16'h0008,1};
        tbl[2]  = '{1,0,3,1,0,0,6,1,0,0,0,0, 1,1,16'h0008,1};
        tbl[3]  = '{1,0,3,1,0,0,6,1,0,0,1,3, 0,0,16'h0000,0};
        tbl[4]  = '{1,0,0,0,0,0,0,1,1,0,0,0, 0,0,16'h0000,0};
        tbl[5]  = '{1,0,0,1,0,1,6,1,0,0,0,0, 0,0,16'h0000,0};
        tbl[6]  = '{1,0,0,0,0,0,1,1,1,0,0,0, 0,0,16'h0002,1};
        tbl[7]  = '{1,0,0,0,0,0,2,1,1,0,0,0, 0,0,16'h0006,2};
        tbl[8]  = '{1,0,0,0,0,0,4,1,1,0,0,0, 1,1,16'h0006,2};
        tbl[9]  = '{1,0,0,0,0,0,4,1,1,0,1,1, 0,0,16'h0014,2};
        tbl[10] = '{0,0,0,0,0,0,0,0,0,0,1,2, 0,0,16'h0010,1};
        tbl[11] = '{0,0,0,0,0,0,0,0,0,0,1,4, 0,0,16'h0000,0};
        tbl[12] = '{1,0,0,0,0,0,5,1,1,0,0,0, 0,0,16'h0020,1};
        tbl[13] = '{1,0,0,0,0,0,5,1,1,0,0,0, 1,1,16'h0020,1};
        tbl[14] = '{1,1,0,0,0,0,5,1,1,0,0,0, 0,0,16'h0020,1};
        tbl[15] = '{1,0,0,0,0,0,5,1,1,0,1,5, 0,0,16'h0020,1};
        tbl[16] = '{0,0,0,0,0,0,0,0,0,0,1,5, 0,0,16'h0000,0};
        tbl[17] = '{1,0,0,0,0,0,7,1,1,0,0,0, 0,0,16'h0080,1};
        tbl[18] = '{1,0,0,0,7,1,8,1,0,1,0,0, 1,0,16'h0080,1};
        tbl[19] = '{1,0,0,0,7,0,8,1,0,0,0,0, 0,0,16'h0080,1};
        tbl[20] = '{0,0,7,1,0,0,8,1,0,0,0,0, 0,0,16'h0080,1};
        tbl[21] = '{0,0,0,0,0,0,0,0,0,0,1,7, 0,0,16'h0000,0};

        rst_n = 1'b0;
        idle();
        #12;
        chk("reset_pending", 32'(ldPending), 0);
        chk("reset_count", 32'(ldCount), 0);
        chk("reset_sberr", 32'(sbErr), 0);
        chk("reset_stallcnt", 32'(stallCnt), 0);
        chk("reset_stall", 32'(stall_ID), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_stall", i), 32'(stall_ID), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_bubble", i), 32'(bubble_EX), 32'(tbl[i].bu));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_pend", i), 32'(ldPending), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_count", i), 32'(ldCount), 32'(tbl[i].cnt));
        end
        chk("tbl_stallcnt", 32'(stallCnt), 5);
        chk("tbl_sberr", 32'(sbErr), 0);

        // Frozen pipe: stall without bubble, stall counter still advances
        @(negedge clk);
        t = '{1,0,0,0,0,0,7,1,1,0,0,0, 0,0,16'h0,0};
        drive(t);
        @(negedge clk);
        t = '{1,0,7,1,0,0,9,1,0,1,0,0, 0,0,16'h0,0};
        drive(t);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ms_stall", 32'(stall_ID), 1);
            chk("ms_bubble", 32'(bubble_EX), 0);
            @(negedge clk);
        end
        chk("ms_stallcnt", 32'(stallCnt), 8);
        t = '{0,0,0,0,0,0,0,0,0,0,1,7, 0,0,16'h0,0};
        drive(t);

        // Spurious writeback raises a sticky error
        @(negedge clk);
        t = '{0,0,0,0,0,0,0,0,0,0,1,9, 0,0,16'h0,0};
        drive(t);
        @(negedge clk);
        idle();
        chk("err_set", 32'(sbErr), 1);
        chk("err_pend", 32'(ldPending), 0);
        chk("err_count", 32'(ldCount), 0);
        repeat (2) @(negedge clk);
        chk("err_sticky", 32'(sbErr), 1);

        // Reset while stalled
        t = '{1,0,0,0,0,0,7,1,1,0,0,0, 0,0,16'h0,0};
        drive(t);
        @(negedge clk);
        t = '{1,0,7,1,0,0,9,1,0,0,0,0, 0,0,16'h0,0};
        drive(t);
        #1;
        chk("pre_rst_stall", 32'(stall_ID), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_stall", 32'(stall_ID), 0);
        chk("rst_bubble", 32'(bubble_EX), 0);
        chk("rst_pend", 32'(ldPending), 0);
        chk("rst_count", 32'(ldCount), 0);
        chk("rst_sberr", 32'(sbErr), 0);
        chk("rst_stallcnt", 32'(stallCnt), 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Random traffic against the model
        m_pend = '0;
        m_err = 1'b0;
        m_stall_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            valid_ID  = ($urandom_range(0, 9) != 0);
            flush_ID  = ($urandom_range(0, 7) == 0);
            rdReg1_ID = 4'($urandom_range(0, 7));
            rdReg2_ID = 4'($urandom_range(0, 7));
            rdEn1_ID  = 1'($urandom_range(0, 1));
            rdEn2_ID  = 1'($urandom_range(0, 1));
            wrReg_ID  = 4'($urandom_range(0, 7));
            wrEn_ID   = ($urandom_range(0, 4) != 0);
            isLoad_ID = ($urandom_range(0, 4) < 2);
            memStall  = ($urandom_range(0, 9) == 0);
            ldDone_WB = 1'b0;
            ldReg_WB  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                if (m_pend != 0) begin
                    pick = 4'($urandom_range(0, 15));
                    while (!m_pend[pick]) pick = pick + 4'd1;
                    ldDone_WB = 1'b1;
                    ldReg_WB  = pick;
                end else if ($urandom_range(0, 9) == 0) begin
                    ldDone_WB = 1'b1;
                end
            end
            #1;
            exp_st = model_stall();
            chk("rnd_stall", 32'(stall_ID), 32'(exp_st));
            chk("rnd_bubble", 32'(bubble_EX), 32'(exp_st && !memStall));
            @(posedge clk);
            if (ldDone_WB) begin
                if (m_pend[ldReg_WB]) m_pend[ldReg_WB] = 1'b0;
                else m_err = 1'b1;
            end
            if (valid_ID && !flush_ID && !exp_st && !memStall && isLoad_ID && wrEn_ID && wrReg_ID != 0)
                m_pend[wrReg_ID] = 1'b1;
            if (exp_st) m_stall_cnt++;
            #1;
            chk("rnd_pend", 32'(ldPending), 32'(m_pend));
            chk("rnd_count", 32'(ldCount), 32'($countones(m_pend)));
            chk("rnd_sberr", 32'(sbErr), 32'(m_err));
            chk("rnd_stallcnt", 32'(stallCnt), 32'(m_stall_cnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ld_use_stall.md
Name: ld_use_stall

Overview:
- Producer-side companion to the ID-stage forwarding selector: tracks in-flight loads whose data cannot be forwarded until they complete at WB.
- Stalls IF/ID and injects an EX bubble whenever the ID instruction reads, or overwrites, a register with an outstanding load.
- Sits in ID beside the forwarding logic. Holds a per-register load scoreboard, an outstanding-load counter, a sticky protocol-error flag and a saturating stall-cycle counter.

Parameters:
NUM_REGS, 16, architectural registers; register 0 is hard-wired zero
REG_W, 4, register index width (log2 NUM_REGS)
MAX_LD, 2, maximum loads in flight
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
valid_ID  in  1  ID holds a real instruction
flush_ID  in  1  ID instruction is squashed this cycle
rdReg1_ID  in  REG_W  source register 1
rdReg2_ID  in  REG_W  source register 2
rdEn1_ID  in  1  source 1 is read
rdEn2_ID  in  1  source 2 is read
wrReg_ID  in  REG_W  destination register
wrEn_ID  in  1  instruction writes wrReg_ID
isLoad_ID  in  1  instruction is a load
memStall  in  1  global pipeline freeze from memory
ldDone_WB  in  1  load data is written back this cycle
ldReg_WB  in  REG_W  destination of the completing load
stall_ID  out  1  hold PC and the IF/ID register
bubble_EX  out  1  insert a NOP into ID/EX
ldPending  out  NUM_REGS  scoreboard, bit r = load to r in flight
ldCount  out  log2(MAX_LD)+1  loads in flight
sbErr  out  1  sticky: ldDone_WB for a non-pending register
stallCnt  out  CNT_W  cycles with stall_ID=1, saturating

Behaviour:
- Reset (async, rst_n=0): ldPending=0, ldCount=0, sbErr=0, stallCnt=0. stall_ID and bubble_EX then evaluate to 0 because the scoreboard is clear.
- rel(r) = ldDone_WB & (ldReg_WB==r). A register being released this cycle counts as not pending, because forwarding supplies it from WB the same cycle.
- RAW condition for source n: rdEn_n & rdReg_n!=0 & ldPending[rdReg_n] & ~rel(rdReg_n).
- WAW condition: wrEn_ID & wrReg_ID!=0 & ldPending[wrReg_ID] & ~rel(wrReg_ID).
- Structural condition: isLoad_ID & wrEn_ID & ldCount==MAX_LD & ~ldDone_WB.
- stall_ID = valid_ID & ~flush_ID & (RAW1 | RAW2 | WAW | structural). It is combinational from registered state and ID inputs, with zero added latency.
- bubble_EX = stall_ID & ~memStall. Under memStall the whole pipe freezes, so no bubble is inserted.
- advance = valid_ID & ~flush_ID & ~stall_ID & ~memStall.
- Load issue: issue = advance & isLoad_ID & wrEn_ID & wrReg_ID!=0. A load to r0 is never tracked.
- Clock edge, scoreboard: clear bit ldReg_WB if ldDone_WB, then set bit wrReg_ID if issue. Set wins only for a different register, since WAW prevents issuing to a pending register.
- Clock edge, counter: ldCount += issue - (ldDone_WB & pending). ldCount never exceeds MAX_LD and never goes below 0.
- ldDone_WB when ldPending[ldReg_WB]==0, or ldReg_WB==0: no state change except sbErr<=1. sbErr clears only on reset.
- stallCnt increments on every cycle with stall_ID=1 and holds at all-ones.
- flush_ID: suppresses both stall and issue for that cycle. Loads already past ID stay tracked until ldDone_WB.
- memStall: scoreboard still clears on ldDone_WB. Issue is blocked.
- Reset mid-operation clears all tracking. The pipeline is flushed by the same reset.

Decomposition:
- Shared package/defines: REG_W, NUM_REGS, register-0 constant, MAX_LD default. These sit alongside the existing forwarding-select codes.
- One natural sub-module, ld_scoreboard: a NUM_REGS-bit set/clear array with per-index pending lookup, instantiated once.
- Hazard equations, counter, sbErr and stallCnt stay in the top module.

Test Plan:
- Load r3 issues at cycle 0; add reading r3 enters ID at cycle 1 -> stall_ID=1, bubble_EX=1 until ldDone_WB with ldReg_WB=3. In that release cycle stall_ID=0 and ldPending[3] returns to 0.
- Load r0, then an instruction reading r0 -> ldPending stays 0, ldCount stays 0, stall_ID never asserts.
- MAX_LD=2: loads to r1 and r2 outstanding, third load to r4 in ID -> stall_ID=1. ldDone_WB for r1 in the same cycle -> stall_ID=0 and the load issues; ldCount stays 2, ldPending=0x0014.
- Load r5 pending, ID load to r5 (WAW) -> stall_ID=1. Raising flush_ID the same cycle -> stall_ID=0, no issue, ldCount unchanged.
- Load r7 pending, reader of r7 with memStall=1 -> stall_ID=1, bubble_EX=0. After 3 stall cycles stallCnt=3.
- ldDone_WB with ldReg_WB=9 while ldPending[9]=0 -> sbErr=1 and stays 1. Assert rst_n=0 mid-stall -> all outputs 0 immediately.
